// File: rtl/av_bfm_master_engine_if.sv
// Avalon-MM master bus bundle used by av_bfm_master_engine.
//   master modport: drives address/burstcount/writedata/byteenable/write/read,
//                   samples waitrequest/readdatavalid/response/readdata.
//   slave modport : the mirror image, for a slave model or interconnect.
interface av_bfm_master_engine_if #(
   parameter int unsigned dw     = 32,
   parameter int unsigned aw     = 32,
   parameter int unsigned burstw = 8
);
   logic [aw-1:0]     av_address_o;
   logic [burstw-1:0] av_burstcount_o;
   logic [dw-1:0]     av_writedata_o;
   logic [dw/8-1:0]   av_byteenable_o;
   logic              av_write_o;
   logic              av_read_o;
   logic              av_waitrequest_i;
   logic              av_readdatavalid_i;
   logic [1:0]        av_response_i;
   logic [dw-1:0]     av_readdata_i;

   modport master (
      output av_address_o, av_burstcount_o, av_writedata_o, av_byteenable_o,
             av_write_o, av_read_o,
      input  av_waitrequest_i, av_readdatavalid_i, av_response_i, av_readdata_i
   );

   modport slave (
      input  av_address_o, av_burstcount_o, av_writedata_o, av_byteenable_o,
             av_write_o, av_read_o,
      output av_waitrequest_i, av_readdatavalid_i, av_response_i, av_readdata_i
   );
endinterface

// File: rtl/av_bfm_master_engine.sv
// Avalon-MM burst master engine: accepts one read or write burst command at a
// time and runs it on the Avalon bus.
//   av_clk_i/av_rst_i         : clock (rising edge), async active-low reset
//   cmd_*                     : command channel (valid/ready, write, addr, burst)
//   wr_*                      : write beat stream (valid/ready, data, byte enables)
//   rd_valid_o/rd_data_o      : read beat stream, one cycle after readdatavalid
//   done_o/err_o              : one-cycle completion pulse and its status
//   av                        : Avalon-MM master bus (av_bfm_master_engine_if.master)
// Optional macro AV_MASTER_TIMEOUT_EN adds a stall watchdog of TIMEOUT cycles.
module av_bfm_master_engine #(
   parameter int unsigned dw      = 32,
   parameter int unsigned aw      = 32,
   parameter int unsigned burstw  = 8,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic              av_clk_i,
   input  logic              av_rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [aw-1:0]     cmd_addr_i,
   input  logic [burstw-1:0] cmd_burst_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [dw-1:0]     wr_data_i,
   input  logic [dw/8-1:0]   wr_be_i,
   output logic              rd_valid_o,
   output logic [dw-1:0]     rd_data_o,
   output logic              done_o,
   output logic              err_o,
   av_bfm_master_engine_if.master av
);

   localparam int unsigned BEW = dw / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_RREQ  = 3'd2,
      S_RDATA = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_rd_valid;
   logic [dw-1:0]     r_rd_data;
   logic              r_done;
   logic              r_err;
   logic              r_av_read;
   logic              r_sticky_err;
   logic [aw-1:0]     r_addr;
   logic [burstw-1:0] r_burst;
   logic [burstw-1:0] r_cnt;

   logic w_accept;
   logic w_wr_beat;
   logic w_rreq_ack;
   logic w_rd_beat;
   logic w_rsp_err;
   logic w_last;
   logic w_timeout;

   assign w_accept   = (r_state == S_IDLE) & r_cmd_ready & cmd_valid_i;
   assign w_wr_beat  = (r_state == S_WRITE) & wr_valid_i & ~av.av_waitrequest_i;
   assign w_rreq_ack = (r_state == S_RREQ) & ~av.av_waitrequest_i;
   // A beat arriving in the same cycle the read request is accepted still counts.
   assign w_rd_beat  = av.av_readdatavalid_i & ((r_state == S_RDATA) | w_rreq_ack);
   assign w_rsp_err  = w_rd_beat & (av.av_response_i != 2'b00);
   assign w_last     = (r_cnt == burstw'(1));

`ifdef AV_MASTER_TIMEOUT_EN
   localparam int unsigned TOW = $clog2(TIMEOUT + 1);

   logic [TOW-1:0] r_to_cnt;
   logic           w_busy;
   logic           w_progress;

   assign w_busy     = (r_state == S_WRITE) | (r_state == S_RREQ) | (r_state == S_RDATA);
   assign w_progress = w_wr_beat | w_rreq_ack | w_rd_beat;
   assign w_timeout  = w_busy & ~w_progress & (r_to_cnt == TOW'(TIMEOUT - 1));

   // Consecutive no-progress cycles while a burst is active.
   always_ff @(posedge av_clk_i or negedge av_rst_i) begin
      if (!av_rst_i) begin
         r_to_cnt <= '0;
      end else if (!w_busy || w_progress || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TOW'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Burst FSM with registered handshake, status and read outputs.
   always_ff @(posedge av_clk_i or negedge av_rst_i) begin
      if (!av_rst_i) begin
         r_state      <= S_IDLE;
         r_cmd_ready  <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_av_read    <= 1'b0;
         r_sticky_err <= 1'b0;
         r_addr       <= '0;
         r_burst      <= '0;
         r_cnt        <= '0;
      end else begin
         r_rd_valid <= w_rd_beat;
         r_done     <= 1'b0;
         r_err      <= 1'b0;

         if (w_rd_beat) begin
            r_rd_data    <= av.av_readdata_i;
            r_cnt        <= r_cnt - burstw'(1);
            r_sticky_err <= r_sticky_err | w_rsp_err;
         end

         case (r_state)
            S_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready  <= 1'b0;
                  r_addr       <= cmd_addr_i;
                  r_burst      <= cmd_burst_i;
                  r_cnt        <= cmd_burst_i;
                  r_sticky_err <= 1'b0;
                  if (cmd_burst_i == '0) begin
                     // Zero-length burst: no bus cycle, report an error.
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (cmd_write_i) begin
                     r_state <= S_WRITE;
                  end else begin
                     r_state   <= S_RREQ;
                     r_av_read <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (w_wr_beat) begin
                  r_cnt <= r_cnt - burstw'(1);
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_RREQ: begin
               if (w_rreq_ack) begin
                  r_av_read <= 1'b0;
                  if (w_rd_beat && w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= r_sticky_err | w_rsp_err;
                  end else begin
                     r_state <= S_RDATA;
                  end
               end
            end
            S_RDATA: begin
               if (w_rd_beat && w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_err   <= r_sticky_err | w_rsp_err;
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_timeout) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_av_read <= 1'b0;
         end
      end
   end

   assign cmd_ready_o = r_cmd_ready;
   assign rd_valid_o  = r_rd_valid;
   assign rd_data_o   = r_rd_data;
   assign done_o      = r_done;
   assign err_o       = r_err;

   // Write beats pass straight through while a write burst is active.
   assign wr_ready_o          = (r_state == S_WRITE) & ~av.av_waitrequest_i;
   assign av.av_write_o       = (r_state == S_WRITE) & wr_valid_i;
   assign av.av_writedata_o   = (r_state == S_WRITE) ? wr_data_i : '0;
   assign av.av_byteenable_o  = (r_state == S_WRITE) ? wr_be_i : BEW'(0);
   assign av.av_read_o        = r_av_read;
   assign av.av_address_o     = r_addr;
   assign av.av_burstcount_o  = r_burst;

endmodule

// File: tb/tb_av_bfm_master_engine.sv
// Directed + randomized bench for av_bfm_master_engine; the bench acts as the
// command source, write-beat source and Avalon slave, and predicts every
// output from the bus-protocol rules.
module tb_av_bfm_master_engine;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned BW = 8;

   logic          av_clk_i = 1'b0;
   logic          av_rst_i = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic          cmd_write_i = 1'b0;
   logic [AW-1:0] cmd_addr_i = '0;
   logic [BW-1:0] cmd_burst_i = '0;
   logic          wr_valid_i = 1'b0;
   logic          wr_ready_o;
   logic [DW-1:0] wr_data_i = '0;
   logic [3:0]    wr_be_i = '0;
   logic          rd_valid_o;
   logic [DW-1:0] rd_data_o;
   logic          done_o;
   logic          err_o;

   int total = 0;
   int bad   = 0;

   av_bfm_master_engine_if #(.dw(DW), .aw(AW), .burstw(BW)) av_if ();

   av_bfm_master_engine #(.dw(DW), .aw(AW), .burstw(BW), .TIMEOUT(16)) dut (
      .av_clk_i    (av_clk_i),
      .av_rst_i    (av_rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_burst_i (cmd_burst_i),
      .wr_valid_i  (wr_valid_i),
      .wr_ready_o  (wr_ready_o),
      .wr_data_i   (wr_data_i),
      .wr_be_i     (wr_be_i),
      .rd_valid_o  (rd_valid_o),
      .rd_data_o   (rd_data_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .av          (av_if)
   );

   always #5 av_clk_i = ~av_clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_slave();
      av_if.av_waitrequest_i   = 1'b0;
      av_if.av_readdatavalid_i = 1'b0;
      av_if.av_response_i      = 2'b00;
      av_if.av_readdata_i      = '0;
   endtask

   // All outputs must sit at zero while reset is asserted.
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready_o, 0);
      chk({tag, "_wr_ready"},  wr_ready_o, 0);
      chk({tag, "_rd_valid"},  rd_valid_o, 0);
      chk({tag, "_rd_data"},   rd_data_o, 0);
      chk({tag, "_done"},      done_o, 0);
      chk({tag, "_err"},       err_o, 0);
      chk({tag, "_write"},     av_if.av_write_o, 0);
      chk({tag, "_read"},      av_if.av_read_o, 0);
      chk({tag, "_addr"},      av_if.av_address_o, 0);
      chk({tag, "_bcnt"},      av_if.av_burstcount_o, 0);
      chk({tag, "_wdata"},     av_if.av_writedata_o, 0);
      chk({tag, "_be"},        av_if.av_byteenable_o, 0);
   endtask

   // Present one command; returns at the negedge of the first post-accept cycle.
   task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b);
      int n = 0;
      @(negedge av_clk_i);
      while (!cmd_ready_o && n < 20) begin
         @(negedge av_clk_i);
         n++;
      end
      chk("cmd_ready", cmd_ready_o, 1);
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_burst_i = b;
      @(negedge av_clk_i);
      cmd_valid_i = 1'b0;
      cmd_addr_i  = $urandom;
      cmd_burst_i = BW'($urandom);
      chk("cmd_taken", cmd_ready_o, 0);
   endtask

   // Write burst; waitrequest forced high for stall_len cycles at beat stall_beat.
   task automatic do_write(input logic [AW-1:0] addr, input int burst, input int stall_beat,
                           input int stall_len, input int vpct, input int wpct);
      logic [DW-1:0] dq[$];
      logic [3:0]    bq[$];
      int beat = 0, stalls = 0, cyc = 0, seen = 0;
      logic wv, wt;
      for (int i = 0; i < burst; i++) begin
         dq.push_back($urandom);
         bq.push_back(4'($urandom_range(15)));
      end
      issue_cmd(1'b1, addr, BW'(burst));
      while (beat < burst && cyc < 500) begin
         wv = ($urandom_range(99) < vpct);
         if (beat == stall_beat && stalls < stall_len) begin
            wt = 1'b1;
            wv = 1'b1;
            stalls++;
         end else begin
            wt = ($urandom_range(99) < wpct);
         end
         wr_valid_i = wv;
         wr_data_i  = dq[0];
         wr_be_i    = bq[0];
         av_if.av_waitrequest_i = wt;
         #1;
         chk("wr_strobe", av_if.av_write_o, wv);
         chk("wr_ready", wr_ready_o, !wt);
         chk("wr_addr", av_if.av_address_o, addr);
         chk("wr_bcnt", av_if.av_burstcount_o, burst);
         chk("wr_nodone", done_o, 0);
         if (av_if.av_write_o && !wt) seen++;
         if (wv && !wt) begin
            chk("wr_data", av_if.av_writedata_o, dq[0]);
            chk("wr_be", av_if.av_byteenable_o, bq[0]);
            void'(dq.pop_front());
            void'(bq.pop_front());
            beat++;
         end
         @(negedge av_clk_i);
         cyc++;
      end
      chk("wr_beats", seen, burst);
      wr_valid_i = 1'b1;
      av_if.av_waitrequest_i = 1'b0;
      #1;
      chk("wr_done", done_o, 1);
      chk("wr_err", err_o, 0);
      chk("wr_no_extra", av_if.av_write_o, 0);
      @(negedge av_clk_i);
      wr_valid_i = 1'b0;
      #1;
      chk("wr_done_once", done_o, 0);
   endtask

   // Read burst; beat err_beat answers with SLVERR, dbase!=0 gives data dbase+n.
   task automatic do_read(input logic [AW-1:0] addr, input int burst, input int err_beat,
                          input logic [DW-1:0] dbase, input int rpct, input int wpct);
      int got = 0, cyc = 0;
      logic accepted = 1'b0, any_err = 1'b0, prev_v = 1'b0, counted, wt, rv;
      logic [DW-1:0] prev_d = '0, d;
      issue_cmd(1'b0, addr, BW'(burst));
      while (got < burst && cyc < 500) begin
         wt = accepted ? 1'b0 : ($urandom_range(99) < wpct);
         rv = ($urandom_range(99) < rpct);
         d  = (dbase != 0) ? dbase + DW'(got) : DW'($urandom);
         av_if.av_waitrequest_i   = wt;
         av_if.av_readdatavalid_i = rv;
         av_if.av_readdata_i      = d;
         av_if.av_response_i      = (got == err_beat) ? 2'b10 : 2'b00;
         #1;
         chk("rd_strobe", av_if.av_read_o, !accepted);
         chk("rd_addr", av_if.av_address_o, addr);
         chk("rd_bcnt", av_if.av_burstcount_o, burst);
         chk("rd_valid", rd_valid_o, prev_v);
         if (prev_v) chk("rd_data", rd_data_o, prev_d);
         chk("rd_nodone", done_o, 0);
         counted = rv && (accepted || !wt);
         if (!wt) accepted = 1'b1;
         prev_v = counted;
         prev_d = d;
         if (counted) begin
            if (got == err_beat) any_err = 1'b1;
            got++;
         end
         @(negedge av_clk_i);
         cyc++;
      end
      chk("rd_beats", got, burst);
      av_if.av_waitrequest_i   = 1'b0;
      av_if.av_readdatavalid_i = 1'b1;
      av_if.av_response_i      = 2'b00;
      #1;
      chk("rd_done", done_o, 1);
      chk("rd_err", err_o, any_err);
      chk("rd_last_valid", rd_valid_o, prev_v);
      if (prev_v) chk("rd_last_data", rd_data_o, prev_d);
      chk("rd_strobe_off", av_if.av_read_o, 0);
      @(negedge av_clk_i);
      av_if.av_readdatavalid_i = 1'b0;
      #1;
      chk("rd_done_once", done_o, 0);
      chk("rd_stray_ignored", rd_valid_o, 0);
   endtask

   task automatic do_zero(input logic w);
      issue_cmd(w, 32'h80, 8'd0);
      wr_valid_i = 1'b1;
      #1;
      chk("z_done", done_o, 1);
      chk("z_err", err_o, 1);
      chk("z_write", av_if.av_write_o, 0);
      chk("z_read", av_if.av_read_o, 0);
      @(negedge av_clk_i);
      wr_valid_i = 1'b0;
      #1;
      chk("z_done_once", done_o, 0);
      chk("z_read2", av_if.av_read_o, 0);
   endtask

   initial begin
      idle_slave();
      #1;
      chk_reset_outputs("rst0");
      repeat (3) @(negedge av_clk_i);
      chk_reset_outputs("rst1");
      av_rst_i = 1'b1;

      // Directed: write 0x100 x4 with a 2-cycle stall in front of beat 2.
      do_write(32'h100, 4, 1, 2, 100, 0);
      // Directed: read 0x40 x3, gapped valids, data A/B/C.
      do_read(32'h40, 3, -1, 32'hA, 50, 30);
      // Directed: read x2 with SLVERR on beat 2.
      do_read(32'h240, 2, 1, 32'h55, 70, 0);
      // Directed: read x1 where the single beat lands on the request-accept cycle.
      do_read(32'h300, 1, -1, 32'h77, 100, 0);
      // Directed: zero-length bursts.
      do_zero(1'b0);
      do_zero(1'b1);

      // Directed: reset asserted while beat 2 of 4 is stalled.
      issue_cmd(1'b1, 32'h500, 8'd4);
      wr_valid_i = 1'b1;
      wr_data_i  = 32'h1111_2222;
      wr_be_i    = 4'hF;
      av_if.av_waitrequest_i = 1'b0;
      @(negedge av_clk_i);
      av_if.av_waitrequest_i = 1'b1;
      wr_data_i = 32'h3333_4444;
      #1;
      chk("mid_write", av_if.av_write_o, 1);
      av_rst_i = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(negedge av_clk_i);
         #1;
         chk("rst_hold_nodone", done_o, 0);
      end
      wr_valid_i = 1'b0;
      idle_slave();
      av_rst_i = 1'b1;
      do_write(32'h600, 4, -1, 0, 80, 20);

      // Randomized mix of bursts.
      for (int t = 0; t < 14; t++) begin
         logic [AW-1:0] a;
         int b;
         a = {$urandom_range(32'h0FFF_FFFF), 4'h0};
         b = $urandom_range(1, 8);
         if ($urandom_range(1) == 1)
            do_write(a, b, $urandom_range(b - 1), $urandom_range(3),
                     $urandom_range(40, 100), $urandom_range(0, 60));
         else
            do_read(a, b, ($urandom_range(2) == 0) ? $urandom_range(b - 1) : -1, '0,
                    $urandom_range(30, 100), $urandom_range(0, 70));
      end

`ifdef AV_MASTER_TIMEOUT_EN
      // Watchdog: waitrequest stuck high on a read request.
      begin
         int hi = 0, n = 0;
         issue_cmd(1'b0, 32'h700, 8'd2);
         av_if.av_waitrequest_i = 1'b1;
         #1;
         while (!done_o && n < 100) begin
            if (av_if.av_read_o) hi++;
            @(negedge av_clk_i);
            #1;
            n++;
         end
         chk("to_read_cycles", hi, 16);
         chk("to_done", done_o, 1);
         chk("to_err", err_o, 1);
         chk("to_read_off", av_if.av_read_o, 0);
         av_if.av_waitrequest_i = 1'b0;
         @(negedge av_clk_i);
         #1;
         chk("to_done_once", done_o, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/av_bfm_master_engine.md
AV_BFM_MASTER_ENGINE -- requirements
Module: av_bfm_master_engine

Interface
REQ-001 SHALL have parameter dw, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter aw, default 32, address width.
REQ-003 SHALL have parameter burstw, default 8, burstcount width.
REQ-004 SHALL have parameter TIMEOUT, default 256, stall-cycle limit, used only with AV_MASTER_TIMEOUT_EN.
REQ-005 av_clk_i  in  1  clock; all logic on rising edge.
REQ-006 av_rst_i  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid_i  in  1  command request.
REQ-008 cmd_ready_o  out  1  command accepted when both high.
REQ-009 cmd_write_i  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_addr_i  in  aw  burst start address.
REQ-011 cmd_burst_i  in  burstw  beat count.
REQ-012 wr_valid_i  in  1  write beat available.
REQ-013 wr_ready_o  out  1  write beat consumed when both high.
REQ-014 wr_data_i  in  dw  write beat data.
REQ-015 wr_be_i  in  dw/8  write beat byte enables.
REQ-016 rd_valid_o  out  1  read beat valid, single cycle, no backpressure.
REQ-017 rd_data_o  out  dw  read beat data.
REQ-018 done_o  out  1  one-cycle pulse at command completion.
REQ-019 err_o  out  1  valid with done_o; 1 = slave error, zero burst or timeout.
REQ-020 av_address_o, av_burstcount_o  out  aw, burstw  Avalon address and burstcount.
REQ-021 av_writedata_o, av_byteenable_o  out  dw, dw/8  Avalon write data and byte enables.
REQ-022 av_write_o, av_read_o  out  1 each  Avalon write and read strobes.
REQ-023 av_waitrequest_i, av_readdatavalid_i  in  1 each  Avalon slave stall and read-data-valid.
REQ-024 av_response_i, av_readdata_i  in  2, dw  Avalon response (00 = OKAY) and read data.

Function
REQ-025 FSM states SHALL be IDLE, WRITE, RREQ, RDATA, DONE; cmd_ready_o = (state==IDLE).
REQ-026 On acceptance, SHALL latch addr and burst into av_address_o and av_burstcount_o, held constant for the whole burst, and load beat counter = cmd_burst_i.
REQ-027 cmd_burst_i==0 SHALL issue no bus cycle: go to DONE, done_o=1 with err_o=1 next cycle.
REQ-028 WRITE: av_write_o = wr_valid_i (combinational); av_writedata_o/av_byteenable_o = wr_data_i/wr_be_i; wr_ready_o = !av_waitrequest_i; a beat completes when wr_valid_i & !av_waitrequest_i; master stall (wr_valid_i=0) SHALL be legal mid-burst.
REQ-029 WRITE: counter decrements per beat; last beat -> DONE; err_o=0.
REQ-030 RREQ: av_read_o=1 until the cycle with !av_waitrequest_i, then RDATA with av_read_o=0 next cycle.
REQ-031 RDATA: each av_readdatavalid_i SHALL register to rd_valid_o/rd_data_o one cycle later and decrement the counter; any beat with av_response_i!=00 SHALL set a sticky error flag; last beat -> DONE.
REQ-032 av_readdatavalid_i outside RDATA SHALL be ignored.
REQ-033 A readdatavalid coinciding with the RREQ acceptance cycle SHALL be counted, not lost.
REQ-034 DONE: done_o=1 and err_o=sticky flag for exactly one cycle, then IDLE; sticky flag cleared on the next acceptance.

Reset
REQ-035 While av_rst_i=0: state IDLE, and cmd_ready_o=0, wr_ready_o=0, rd_valid_o=0, done_o=0, err_o=0, av_write_o=0, av_read_o=0, all data/address/burstcount outputs 0; a reset mid-burst SHALL abandon the burst with no done_o.

Configuration
REQ-036 With AV_MASTER_TIMEOUT_EN defined, a counter SHALL count consecutive cycles in WRITE/RREQ/RDATA without beat or request progress; reaching TIMEOUT SHALL drop strobes and go to DONE with err_o=1.
REQ-037 Without AV_MASTER_TIMEOUT_EN there SHALL be no counter, and the block SHALL wait indefinitely.

Verification
REQ-038 Write addr 0x100, burst 4, waitrequest high 2 cycles before beat 2 -> exactly 4 beats transferred, address/burstcount stable, done_o=1 with err_o=0.
REQ-039 Read addr 0x40, burst 3, readdatavalid with gaps, data 0xA,0xB,0xC -> rd_valid_o 3 pulses in order, each 1 cycle after input; done err_o=0.
REQ-040 Read burst 2, beat 2 response 10 -> both beats delivered, done_o with err_o=1.
REQ-041 Command burst 0 -> no av_read_o/av_write_o, done_o with err_o=1 in the next cycle.
REQ-042 av_rst_i low during beat 2 of 4 -> all outputs 0 immediately, no done_o, next command runs normally.
REQ-043 With AV_MASTER_TIMEOUT_EN and TIMEOUT=16, waitrequest stuck high -> av_read_o drops after 16 cycles, done_o with err_o=1.
